// File: rtl/spi_pixel_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// spi_pixel_rx_fifo_if
// Pixel stream handshake between the SPI pixel receiver and its consumer.
//   pixel_data  : head word of the receive FIFO
//   pixel_first : head word is the first pixel of a chip-select frame
//   pixel_valid : FIFO non-empty
//   pixel_ready : consumer takes the head when pixel_valid & pixel_ready
// master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface spi_pixel_rx_fifo_if #(
   parameter int BITS_PER_PIXEL = 24
);
   logic [BITS_PER_PIXEL-1:0] pixel_data;
   logic                      pixel_first;
   logic                      pixel_valid;
   logic                      pixel_ready;

   modport master (
      output pixel_data,
      output pixel_first,
      output pixel_valid,
      input  pixel_ready
   );

   modport slave (
      input  pixel_data,
      input  pixel_first,
      input  pixel_valid,
      output pixel_ready
   );
endinterface

// File: rtl/spi_pixel_rx_fifo.sv
// ----------------------------------------------------------------------------
// spi_pixel_rx_fifo
// SPI pixel receiver running entirely in the system clock domain. The SPI
// pins are oversampled, MSB-first pixels are assembled inside chip-select
// frames and completed pixels are queued in a small FIFO.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   spi_clk        : asynchronous SPI clock from host
//   spi_mosi       : asynchronous SPI data
//   spi_cs_n       : asynchronous chip select, active low
//   px             : pixel stream (data / first / valid / ready)
//   overflow       : sticky, a completed pixel was dropped on a full FIFO
//   partial_error  : sticky, CS rose with an incomplete pixel pending
// ----------------------------------------------------------------------------
module spi_pixel_rx_fifo #(
   parameter int BITS_PER_PIXEL = 24,
   parameter int FIFO_DEPTH     = 8,
   parameter int SAMPLE_EDGE    = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        spi_clk,
   input  logic                        spi_mosi,
   input  logic                        spi_cs_n,
   spi_pixel_rx_fifo_if.master         px,
   output logic                        overflow,
   output logic                        partial_error
);
   localparam int W    = BITS_PER_PIXEL;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int CNTW = $clog2(BITS_PER_PIXEL);
   localparam logic            SE   = (SAMPLE_EDGE != 0);
   localparam logic [CNTW-1:0] LAST = CNTW'(BITS_PER_PIXEL - 1);

   // ---------------- synchronisers ----------------
   // [0] first stage, [1] second stage, [2] edge-detect history
   logic [2:0] r_sclk_s;
   logic [2:0] r_cs_s;
   logic [1:0] r_mosi_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sclk_s <= {3{SE}};
         r_cs_s   <= 3'b111;
         r_mosi_s <= 2'b00;
      end else begin
         r_sclk_s <= {r_sclk_s[1:0], spi_clk};
         r_cs_s   <= {r_cs_s[1:0], spi_cs_n};
         r_mosi_s <= {r_mosi_s[0], spi_mosi};
      end
   end

   logic w_sclk_edge, w_strobe, w_cs_rise;
   // mosi stage [1] lines up with the spi_clk stage [1] that shows the edge
   assign w_sclk_edge = SE ? (~r_sclk_s[1] &  r_sclk_s[2])
                           : ( r_sclk_s[1] & ~r_sclk_s[2]);
   assign w_strobe    = w_sclk_edge & ~r_cs_s[1];
   assign w_cs_rise   = r_cs_s[1] & ~r_cs_s[2];

   // ---------------- pixel assembly ----------------
   logic [W-1:0]    r_shift;
   logic [CNTW-1:0] r_cnt;
   logic            r_first;
   logic            r_push;
   logic            r_push_first;

   // r_shift holds the completed word during the r_push cycle: the spi_clk
   // period constraint keeps the next strobe at least 4 cycles away.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift       <= '0;
         r_cnt         <= '0;
         r_first       <= 1'b1;
         r_push        <= 1'b0;
         r_push_first  <= 1'b0;
         partial_error <= 1'b0;
      end else begin
         r_push <= 1'b0;
         if (w_strobe) begin
            r_shift <= {r_shift[W-2:0], r_mosi_s[1]};
            if (r_cnt == LAST) begin
               r_cnt        <= '0;
               r_push       <= 1'b1;
               r_push_first <= r_first;
               r_first      <= 1'b0;
            end else begin
               r_cnt <= r_cnt + CNTW'(1);
            end
         end else if (w_cs_rise) begin
            // end of frame: drop any incomplete pixel, next word opens a frame
            r_cnt   <= '0;
            r_first <= 1'b1;
            if (r_cnt != '0) partial_error <= 1'b1;
         end
      end
   end

   // ---------------- FIFO ----------------
   logic [W:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_valid;

   logic          w_full, w_pop, w_wr;
   logic [CW-1:0] w_cnt_next;
   logic [W:0]    w_head;

   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_pop      = r_valid & px.pixel_ready;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign w_wr       = r_push & (~w_full | w_pop);
   assign w_cnt_next = r_count + CW'(w_wr) - CW'(w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         r_count <= w_cnt_next;
         r_valid <= (w_cnt_next != '0);
         if (r_push && w_full && !w_pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_wr) r_mem[r_wptr] <= {r_push_first, r_shift};
   end

   // storage is not cleared on reset, so gate the head with valid
   assign w_head         = r_mem[r_rptr];
   assign px.pixel_data  = r_valid ? w_head[W-1:0] : '0;
   assign px.pixel_first = r_valid & w_head[W];
   assign px.pixel_valid = r_valid;

endmodule

// File: doc/spi_pixel_rx_fifo.md
Name: spi_pixel_rx_fifo

Overview:
- Next-generation SPI pixel receiver for the hub75 controller.
- Runs entirely in the system clock domain:
  - oversamples spi_clk, spi_mosi and spi_cs_n through synchronisers;
  - assembles MSB-first pixels of parametrised width, framed by chip select;
  - buffers completed pixels in a FIFO with a valid/ready handshake toward the framebuffer writer.
- Adds CS framing, frame-start marking, partial-word detection, overflow detection and selectable sample edge.

Parameters:
- BITS_PER_PIXEL, 24, pixel word width (>=2).
- FIFO_DEPTH, 8, FIFO entries (power of two, >=2).
- SAMPLE_EDGE, 0, 0 = sample spi_mosi on spi_clk rising edge, 1 = falling edge.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- spi_clk  in  1  asynchronous SPI clock from host.
- spi_mosi  in  1  asynchronous SPI data.
- spi_cs_n  in  1  asynchronous chip select, active low.
- pixel_data  out  BITS_PER_PIXEL  FIFO head word.
- pixel_first  out  1  head word is the first pixel after CS assertion.
- pixel_valid  out  1  FIFO non-empty.
- pixel_ready  in  1  consumer accepts head when pixel_valid & pixel_ready.
- overflow  out  1  sticky: a completed pixel was dropped because the FIFO was full.
- partial_error  out  1  sticky: CS deasserted with 1..BITS_PER_PIXEL-1 bits pending.

Behaviour:
- Reset (synchronous, active-high) sets:
  - pixel_valid=0, pixel_data=0, pixel_first=0;
  - overflow=0, partial_error=0;
  - FIFO pointers/count=0, bit counter=0, shift register=0, first flag=1;
  - synchroniser flops: spi_clk and cs_n stages to idle levels (spi_clk=SAMPLE_EDGE, cs_n=1).
  - Reset mid-pixel discards all partial and buffered data.
- Synchronisation:
  - Each SPI input passes through 2 flops, plus a third flop on spi_clk and spi_cs_n for edge detection.
  - Sample strobe = selected edge of synced spi_clk while synced cs_n=0.
  - spi_mosi is taken from its 2nd sync stage, aligned with the spi_clk stage used for the edge.
  - Constraint: spi_clk period >= 4 clk periods; host sets spi_mosi at least 2 clk before the sample edge.
- Assembly:
  - On each sample strobe: shift register shifts left and inserts mosi at LSB; bit counter increments.
  - When the counter reaches BITS_PER_PIXEL-1 on a strobe, the completed word (including the current bit) is pushed the next clk cycle; the counter wraps to 0.
  - Word is tagged with the first flag, which then clears.
- CS framing:
  - Synced cs_n rising edge: counter resets to 0 and the first flag sets to 1.
  - If counter was nonzero at that edge, partial_error sets and the bits are discarded.
  - A cs_n falling edge has no action beyond enabling strobes.
  - A strobe and a cs_n rising edge in the same cycle cannot occur: strobes require cs_n low.
- FIFO:
  - Push and pop in the same cycle: both occur and count is unchanged.
  - Push when full and no pop that cycle: word dropped, overflow sets.
  - Push when full with a pop that same cycle: succeeds.
  - pixel_valid is registered and rises the cycle after the push into an empty FIFO. Total latency, final sample strobe to pixel_valid, is 2 clk.
  - pixel_data/pixel_first are stable while pixel_valid & !pixel_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear only on reset.

Test Plan:
- Reset, CS low, send 24 bits 0xA5C3F0 MSB-first, CS high -> exactly one pixel 0xA5C3F0 with pixel_first=1; pixel_valid 2 clk after the last sample edge; no flags.
- One CS frame with 3 pixels 0x000001, 0x800000, 0xFFFFFF, pixel_ready=1 -> three pixels in order; pixel_first=1,0,0.
- pixel_ready=0, send 9 pixels with FIFO_DEPTH=8 -> FIFO holds first 8, 9th dropped, overflow=1. Then pixel_ready=1 -> the 8 original words drain in order, pixel_valid falls.
- Send 10 bits then CS high, then a full pixel 0x123456 -> partial_error=1; only 0x123456 output, with pixel_first=1.
- SAMPLE_EDGE=1 build, data changing on rising edge and sampled on falling edge, 0x5A5A5A -> 0x5A5A5A received. Assert reset mid-pixel, then send 0x0F0F0F -> only 0x0F0F0F output, flags 0.
- Continuous pop while pushing at maximum rate (spi_clk = clk/4) for 64 pixels of an incrementing pattern -> all 64 received in order, overflow=0.
